// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: funct3 width codes,
// the mem state enum and the EX/MEM and MEM/WB flow payloads.
package mem_access_stage_pkg;

  localparam int unsigned XLEN_W     = 32;
  localparam int unsigned ADDR_BITS  = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FUNCT3_W   = 3;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  mem_write;
    logic [FUNCT3_W-1:0]   funct3;
    logic [ADDR_BITS-1:0]  addr;
    logic [XLEN_W-1:0]     store_data;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_W-1:0]     alu_result;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_W-1:0]     wb_data;
    logic                  misaligned;
  } mem_wb_t;

  // Halfwords must be 2-byte aligned, words 4-byte aligned.
  function automatic logic is_misaligned(input logic [FUNCT3_W-1:0] f3,
                                         input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: is_misaligned = lo[0];
      F3_W:        is_misaligned = (lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Byte-lane alignment: store strobes/lane replication and load extraction
// with sign or zero extension.
module load_store_align
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [1:0]          addr_lo,
  input  logic [XLEN-1:0]     store_data,
  input  logic [XLEN-1:0]     rdata,
  output logic [3:0]          wstrb,
  output logic [XLEN-1:0]     wdata,
  output logic [XLEN-1:0]     load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Store side keys on the size bits only; sign bit is meaningless for stores.
  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores over a ready/valid data
// port, formats load results and stalls upstream while an access is open.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic              in_reg_write,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_alu_result,
  output logic              mem_stall,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_wb_data,
  output logic              out_misaligned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_wstrb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  mem_state_e      state_q, state_d;
  mem_wb_t         wb;
  logic            is_mem, misaligned, mem_op, from_mem;
  logic [3:0]      strb;
  logic [XLEN-1:0] load_data;

  assign is_mem     = in_valid & (in_mem_read | in_mem_write);
  assign misaligned = is_mem & is_misaligned(in_funct3, in_addr[1:0]);
  assign mem_op     = is_mem & ~misaligned & ~kill;

  load_store_align #(.XLEN(XLEN)) u_align (
    .funct3     (in_funct3),
    .addr_lo    (in_addr[1:0]),
    .store_data (in_store_data),
    .rdata      (dmem_rdata),
    .wstrb      (strb),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  // EX/MEM holds the request fields stable under stall.
  assign dmem_we    = in_mem_write;
  assign dmem_addr  = {in_addr[ADDR_W-1:2], 2'b00};
  assign dmem_wstrb = in_mem_write ? strb : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    dmem_req      = 1'b0;
    mem_stall     = 1'b0;
    from_mem      = 1'b0;
    wb.valid      = 1'b0;
    wb.misaligned = 1'b0;
    case (state_q)
      ST_IDLE, ST_REQ: begin
        dmem_req = mem_op;
        if (mem_op) begin
          if (dmem_ready && in_mem_write) begin
            state_d  = ST_IDLE;
            wb.valid = 1'b1;
          end else begin
            state_d   = dmem_ready ? ST_RESP : ST_REQ;
            mem_stall = 1'b1;
          end
        end else begin
          state_d       = ST_IDLE;
          wb.valid      = in_valid & ~kill;
          wb.misaligned = misaligned & ~kill;
        end
      end
      ST_RESP: begin
        from_mem  = 1'b1;
        mem_stall = ~dmem_rvalid;
        if (dmem_rvalid)  state_d = ST_IDLE;
        else if (kill)    state_d = ST_DRAIN;
        wb.valid = dmem_rvalid & ~kill;
      end
      ST_DRAIN: begin
        // Hold the pipeline until the orphaned response has been swallowed.
        mem_stall = 1'b1;
        if (dmem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      state_d       = ST_IDLE;
      dmem_req      = 1'b0;
      mem_stall     = 1'b0;
      wb.valid      = 1'b0;
      wb.misaligned = 1'b0;
    end
    wb.reg_write = wb.valid & in_reg_write & ~wb.misaligned;
    wb.rd        = in_rd;
    wb.wb_data   = from_mem ? load_data : in_alu_result;
  end

  assign out_valid      = wb.valid;
  assign out_reg_write  = wb.reg_write;
  assign out_rd         = wb.rd;
  assign out_wb_data    = wb.wb_data;
  assign out_misaligned = wb.misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk, reset, kill;
  logic        in_valid, in_mem_read, in_mem_write, in_reg_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_store_data, in_alu_result;
  logic [4:0]  in_rd;
  logic        mem_stall, out_valid, out_reg_write, out_misaligned;
  logic [4:0]  out_rd;
  logic [31:0] out_wb_data;
  logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .kill(kill),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_alu_result(in_alu_result),
    .mem_stall(mem_stall), .out_valid(out_valid), .out_reg_write(out_reg_write),
    .out_rd(out_rd), .out_wb_data(out_wb_data), .out_misaligned(out_misaligned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic regw);
    in_valid      = 1'b1;
    in_mem_read   = rd_op;
    in_mem_write  = wr_op;
    in_funct3     = f3;
    in_addr       = addr;
    in_store_data = sdata;
    in_reg_write  = regw;
    in_rd         = 5'd7;
    in_alu_result = 32'h0BAD_0BAD;
  endtask

  task automatic clear_op();
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
    kill = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Load with ready on the first cycle and rvalid the cycle after.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, f3, addr, 32'h0, 1'b1);
    dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    @(negedge clk);
    check({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
    check({tag, "_stall_n"}, {31'b0, mem_stall}, 32'd1);
    check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    @(posedge clk); #1;
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    check({tag, "_stall_n1"}, {31'b0, mem_stall}, 32'd0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_regw"}, {31'b0, out_reg_write}, 32'd1);
    check({tag, "_wb"}, out_wb_data, exp);
    @(posedge clk); #1;
    clear_op();
  endtask

  initial begin
    clear_op();
    in_funct3 = 3'b010; in_addr = 32'h0; in_store_data = 32'h0; in_rd = 5'd0;
    in_alu_result = 32'h0; dmem_rdata = 32'h0;
    reset = 1'b1;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_stall", {31'b0, mem_stall}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_regw", {31'b0, out_reg_write}, 32'd0);
    @(posedge clk); #1;
    clear_op();
    reset = 1'b0;

    do_load("lw",  3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF_0000, 32'h0000_0080);
    do_load("lhu", 3'b101, 32'h102, 32'h80FF_0000, 32'h0000_80FF);
    do_load("lh",  3'b001, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF);

    // SB with ready low for three cycles.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_56AB, 1'b0);
      dmem_ready = (i == 3);
      @(negedge clk);
      check("sb_req", {31'b0, dmem_req}, 32'd1);
      check("sb_we", {31'b0, dmem_we}, 32'd1);
      check("sb_strb", {28'b0, dmem_wstrb}, 32'h2);
      check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      check("sb_addr", dmem_addr, 32'h200);
      check("sb_stall", {31'b0, mem_stall}, (i < 3) ? 32'd1 : 32'd0);
      check("sb_valid", {31'b0, out_valid}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    clear_op();

    // SH to the upper half, accepted immediately.
    @(posedge clk); #1;
    set_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 1'b0);
    dmem_ready = 1'b1;
    @(negedge clk);
    check("sh_strb", {28'b0, dmem_wstrb}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    clear_op();

    // Misaligned LH.
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    @(negedge clk);
    check("mis_flag", {31'b0, out_misaligned}, 32'd1);
    check("mis_req", {31'b0, dmem_req}, 32'd0);
    check("mis_stall", {31'b0, mem_stall}, 32'd0);
    check("mis_regw", {31'b0, out_reg_write}, 32'd0);
    @(posedge clk); #1;
    clear_op();

    // Non-memory instruction passes the ALU result.
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    in_alu_result = 32'h0000_1234;
    @(negedge clk);
    check("alu_wb", out_wb_data, 32'h0000_1234);
    check("alu_valid", {31'b0, out_valid}, 32'd1);
    check("alu_rd", {27'b0, out_rd}, 32'd7);
    check("alu_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    clear_op();

    // Kill in RESP, response two cycles later, then next load issues.
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0; kill = 1'b1;
    @(negedge clk);
    check("kill_stall", {31'b0, mem_stall}, 32'd1);
    check("kill_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    @(negedge clk);
    check("drain_req", {31'b0, dmem_req}, 32'd0);
    check("drain_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("drain_rv_stall", {31'b0, mem_stall}, 32'd1);
    check("drain_rv_valid", {31'b0, out_valid}, 32'd0);
    check("drain_rv_req", {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("post_drain_req", {31'b0, dmem_req}, 32'd1);
    check("post_drain_addr", dmem_addr, 32'h300);
    @(posedge clk); #1;
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0042;
    @(negedge clk);
    check("post_drain_wb", out_wb_data, 32'h0000_0042);
    check("post_drain_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    clear_op();

    // Kill coincident with rvalid: discard and return to IDLE.
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 3'b010, 32'h140, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0; kill = 1'b1; dmem_rvalid = 1'b1;
    @(negedge clk);
    check("killrv_valid", {31'b0, out_valid}, 32'd0);
    check("killrv_regw", {31'b0, out_reg_write}, 32'd0);
    check("killrv_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    check("killrv_idle_req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    clear_op();

    // Reset asserted while a load is in RESP.
    @(posedge clk); #1;
    set_op(1'b1, 1'b0, 3'b010, 32'h180, 32'h0, 1'b1);
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rresp_req", {31'b0, dmem_req}, 32'd0);
    check("rresp_stall", {31'b0, mem_stall}, 32'd0);
    check("rresp_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_op();
    do_load("after_rst", 3'b010, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
